uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Parametrised baud-tick generator for the UART TX and RX paths. It produces a fractional-N oversample tick (`tick_os`), a per-bit tick (`clk_bps`) and a bit-centre tick (`mid_bps`) from the system clock. The divisor is runtime-programmable with a glitch-free update at the next period boundary. A `sync` input re-phases bit timing to an RX start-bit edge. The block sits between the top-level clock and the UART TX/RX bit engines, and replaces the fixed-divide bit-rate counter.

## Interface
- `SYS_RATE`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 921600: reset-default baud rate.
- `OVERSAMPLE`, 16: oversample ticks per bit; must be even and ≥2.
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor.
- Derived `DEF_INT` = floor(SYS_RATE / (BAUD_RATE·OVERSAMPLE)); default 6.
- Derived `DEF_FRAC` = floor(SYS_RATE·2^FRAC_W / (BAUD_RATE·OVERSAMPLE)) mod 2^FRAC_W; default 12.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `band_sig`  in  1  enable; 0 holds the generator idle and cleared.
- `sync`  in  1  one-cycle pulse; restarts bit phase.
- `div_int`  in  DIV_W  integer part of the oversample period, in clk cycles.
- `div_frac`  in  FRAC_W  fractional part, in units of 1/2^FRAC_W cycle.
- `div_load`  in  1  one-cycle pulse; requests a load of `div_int`/`div_frac`.
- `tick_os`  out  1  oversample tick, one cycle wide.
- `clk_bps`  out  1  bit-boundary tick, one cycle wide.
- `mid_bps`  out  1  bit-centre tick, one cycle wide.
- `cfg_ack`  out  1  one-cycle pulse when a new divisor takes effect.

## Operation
- **Registers.** Active divisor (`act_int`, `act_frac`), pending divisor plus pending flag, period counter `cnt` (DIV_W bits), fractional accumulator `acc` (FRAC_W bits), oversample index `os_idx` (clog2(OVERSAMPLE) bits).
- **Reset.**
  - `act_int`=DEF_INT, `act_frac`=DEF_FRAC; pending flag cleared.
  - `cnt`, `acc` and `os_idx` cleared to 0.
  - All outputs 0.
  - Reset mid-operation drops any pending load.
- **Idle (`band_sig`=0).** `cnt`, `acc` and `os_idx` held at 0; all ticks 0.
- **Period length.** At each period start, P = act_int + carry.
  - carry = 1 if acc + act_frac ≥ 2^FRAC_W, else 0.
  - acc ← (acc + act_frac) mod 2^FRAC_W.
  - The long-run mean period is act_int + act_frac/2^FRAC_W.
- **Clamp.** `div_int` < 2 is clamped to 2 when loaded.
- **tick_os.** Asserts at the end of each period.
- **clk_bps.** Asserts together with the tick_os on which `os_idx` wraps from OVERSAMPLE-1 to 0.
- **mid_bps.** Asserts together with the tick_os on which `os_idx` goes from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- **Divisor load.**
  - With `band_sig`=0: `div_load` updates the active divisor at that edge; `cfg_ack` is high the next cycle.
  - With `band_sig`=1: the divisor is stored as pending and applied at the next period boundary (the edge that raises `tick_os`). The period that follows uses the new divisor, and `cfg_ack` coincides with that `tick_os`. `acc` is cleared on apply.
  - A new `div_load` while a load is pending overwrites the pending value; only one `cfg_ack` is issued.
- **sync.** With `band_sig`=1, `sync` clears `cnt`, `acc` and `os_idx`, exactly as a fresh enable does; the pending load is kept.
- **Priority.** `rst` > `band_sig`=0 > `sync` > normal counting.
  - A `sync` on the same edge as a would-be tick suppresses that tick.
  - A `div_load` on the same edge as a boundary is applied at that boundary.

## Timing
- All outputs are registered, with no combinational path from inputs.
- **Enable latency.** Let E1 be the first rising edge that samples `band_sig`=1 (or `sync`=1). The first `tick_os` is high in the cycle after edge E1+P-1. Subsequent ticks are spaced exactly P cycles apart, with P re-evaluated per period.
- **First bit ticks.**
  - The first `mid_bps` comes on the (OVERSAMPLE/2)-th `tick_os`.
  - The first `clk_bps` comes on the OVERSAMPLE-th `tick_os`.
  - `clk_bps` then repeats every OVERSAMPLE ticks.
- **Deassert.** Dropping `band_sig` forces all ticks to 0 from the next cycle.
- **Counter wrap.** `cnt` never exceeds act_int; no wrap-around of `cnt` is possible.

## Test plan
- **Defaults.**
  - Stimulus: `rst` for 2 cycles, then `band_sig`=1.
  - Required: `tick_os` periods repeat 6,7,7,7.
  - Required: `mid_bps` 54 cycles and `clk_bps` 108 cycles after E1, then `clk_bps` every 108 cycles.
- **Integer divide.**
  - Stimulus: load div_int=3, div_frac=0 while idle, then enable.
  - Required: `cfg_ack` 1 cycle after load; `tick_os` every 3 cycles; `mid_bps` at 24; `clk_bps` at 48, 96, ...
- **Live reload.**
  - Stimulus: run at 3/0; pulse `div_load` with 5/0 one cycle after a tick.
  - Required: next tick 2 cycles later, carrying `cfg_ack`; following ticks every 5 cycles.
  - Stimulus: a second load of 4/0 before that boundary.
  - Required: only 4/0 is applied, with a single `cfg_ack`.
- **Re-sync.**
  - Stimulus: running at 3/0, pulse `sync` when `os_idx`=5.
  - Required: the tick due at that edge is suppressed; `mid_bps` follows 24 cycles after `sync` and `clk_bps` 48 cycles after.
- **Clamp.**
  - Stimulus: load div_int=1 (and separately 0).
  - Required: `tick_os` every 2 cycles.
- **Reset mid-operation.**
  - Stimulus: assert `rst` with a load pending and `os_idx`=9.
  - Required: all outputs 0 the next cycle; divisor returns to 6/12; no `cfg_ack`; after release, timing matches the defaults case.

Source files
------------

// File: rtl/uart_baud_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_baud_gen_if                                                           |
// | Control and tick bundle between a UART controller and its baud generator.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_baud_gen_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              band_sig;
    logic              sync;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              tick_os;
    logic              clk_bps;
    logic              mid_bps;
    logic              cfg_ack;

    modport master (
        output band_sig,
        output sync,
        output div_int,
        output div_frac,
        output div_load,
        input  tick_os,
        input  clk_bps,
        input  mid_bps,
        input  cfg_ack
    );

    modport slave (
        input  band_sig,
        input  sync,
        input  div_int,
        input  div_frac,
        input  div_load,
        output tick_os,
        output clk_bps,
        output mid_bps,
        output cfg_ack
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_baud_gen                                                              |
// | Fractional-N oversample tick generator with bit and bit-centre ticks.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_baud_gen #(
    parameter int unsigned SYS_RATE   = 100000000,
    parameter int unsigned BAUD_RATE  = 921600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_baud_gen_if.slave bus
);
    localparam int unsigned     OS_W       = $clog2(OVERSAMPLE);
    localparam longint unsigned C_DEN      = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam longint unsigned C_INT_RAW  = 64'(SYS_RATE) / C_DEN;
    localparam longint unsigned C_FRAC_RAW = (64'(SYS_RATE) << FRAC_W) / C_DEN;
    localparam logic [DIV_W-1:0]  C_DEF_INT  = (C_INT_RAW < 64'd2) ? DIV_W'(2) : DIV_W'(C_INT_RAW);
    localparam logic [FRAC_W-1:0] C_DEF_FRAC = FRAC_W'(C_FRAC_RAW);
    localparam logic [DIV_W-1:0]  C_MIN_INT  = DIV_W'(2);
    localparam logic [OS_W-1:0]   C_OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   C_OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_W-1:0]  act_int_q,   act_int_d;
    logic [FRAC_W-1:0] act_frac_q,  act_frac_d;
    logic              pend_vld_q,  pend_vld_d;
    logic [DIV_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [DIV_W-1:0]  cnt_q,       cnt_d;
    logic [FRAC_W-1:0] acc_q,       acc_d;
    logic              carry_q,     carry_d;
    logic [OS_W-1:0]   os_idx_q,    os_idx_d;
    logic              tick_os_q,   tick_os_d;
    logic              clk_bps_q,   clk_bps_d;
    logic              mid_bps_q,   mid_bps_d;
    logic              cfg_ack_q,   cfg_ack_d;

    logic [DIV_W-1:0]  w_load_int;
    logic [FRAC_W-1:0] w_acc_base;
    logic [FRAC_W:0]   w_sum;
    logic [DIV_W-1:0]  w_last_cnt;

    assign w_load_int = (bus.div_int < C_MIN_INT) ? C_MIN_INT : bus.div_int;
    // A sync restarts the fractional sequence from zero, like a fresh enable.
    assign w_acc_base = bus.sync ? '0 : acc_q;
    assign w_sum      = {1'b0, w_acc_base} + {1'b0, act_frac_q};
    // act_int is never below 2, so subtracting first cannot underflow or overflow.
    assign w_last_cnt = (act_int_q - DIV_W'(1)) + {{(DIV_W-1){1'b0}}, carry_q};

    always_comb begin
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_vld_d  = pend_vld_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        os_idx_d    = os_idx_q;
        tick_os_d   = 1'b0;
        clk_bps_d   = 1'b0;
        mid_bps_d   = 1'b0;
        cfg_ack_d   = 1'b0;

        if (!bus.band_sig) begin
            cnt_d    = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            os_idx_d = '0;
            if (bus.div_load) begin
                act_int_d  = w_load_int;
                act_frac_d = bus.div_frac;
                pend_vld_d = 1'b0;
                cfg_ack_d  = 1'b1;
            end
        end else begin
            if (bus.div_load) begin
                pend_vld_d  = 1'b1;
                pend_int_d  = w_load_int;
                pend_frac_d = bus.div_frac;
            end

            if (bus.sync || (cnt_q == '0)) begin
                // Period start: fix this period's length from the accumulator carry.
                cnt_d   = DIV_W'(1);
                acc_d   = w_sum[FRAC_W-1:0];
                carry_d = w_sum[FRAC_W];
                if (bus.sync) begin
                    os_idx_d = '0;
                end
            end else if (cnt_q == w_last_cnt) begin
                cnt_d     = '0;
                tick_os_d = 1'b1;
                clk_bps_d = (os_idx_q == C_OS_LAST);
                mid_bps_d = (os_idx_q == C_OS_MID);
                os_idx_d  = (os_idx_q == C_OS_LAST) ? '0 : os_idx_q + OS_W'(1);
                if (bus.div_load) begin
                    act_int_d  = w_load_int;
                    act_frac_d = bus.div_frac;
                    pend_vld_d = 1'b0;
                    acc_d      = '0;
                    cfg_ack_d  = 1'b1;
                end else if (pend_vld_q) begin
                    act_int_d  = pend_int_q;
                    act_frac_d = pend_frac_q;
                    pend_vld_d = 1'b0;
                    acc_d      = '0;
                    cfg_ack_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int_q   <= C_DEF_INT;
            act_frac_q  <= C_DEF_FRAC;
            pend_vld_q  <= 1'b0;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            os_idx_q    <= '0;
            tick_os_q   <= 1'b0;
            clk_bps_q   <= 1'b0;
            mid_bps_q   <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_vld_q  <= pend_vld_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            os_idx_q    <= os_idx_d;
            tick_os_q   <= tick_os_d;
            clk_bps_q   <= clk_bps_d;
            mid_bps_q   <= mid_bps_d;
            cfg_ack_q   <= cfg_ack_d;
        end
    end

    assign bus.tick_os = tick_os_q;
    assign bus.clk_bps = clk_bps_q;
    assign bus.mid_bps = mid_bps_q;
    assign bus.cfg_ack = cfg_ack_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// Scoreboard bench for uart_baud_gen: expected tick events are queued by edge
// number from a period model and compared against the DUT every cycle.
module tb_uart_baud_gen;
    localparam int OS       = 16;
    localparam int FRAC_ONE = 16;

    typedef struct {
        int         e;
        logic [3:0] v;   // {tick_os, clk_bps, mid_bps, cfg_ack}
    } ev_t;

    logic clk;
    logic rst;

    uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    uart_baud_gen #(
        .SYS_RATE   (100000000),
        .BAUD_RATE  (921600),
        .OVERSAMPLE (16),
        .DIV_W      (16),
        .FRAC_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  checks  = 0;
    int  errors  = 0;
    int  edge_no = 0;
    ev_t exp_q[$];
    int  m_t, m_acc, m_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_ev(input int e, input logic [3:0] v);
        ev_t x;
        x.e = e;
        x.v = v;
        exp_q.push_back(x);
    endtask

    task automatic model_start(input int e1);
        m_t   = e1 - 1;
        m_acc = 0;
        m_k   = 0;
    endtask

    task automatic model_ticks(input int iv, input int fv, input int n);
        for (int i = 0; i < n; i++) begin
            int s;
            s     = m_acc + fv;
            m_t   = m_t + iv + ((s >= FRAC_ONE) ? 1 : 0);
            m_acc = s % FRAC_ONE;
            m_k   = m_k + 1;
            push_ev(m_t, {1'b1, (m_k % OS) == 0, (m_k % OS) == OS / 2, 1'b0});
        end
    endtask

    task automatic model_ack_last();
        ev_t x;
        x = exp_q.pop_back();
        x.v[0] = 1'b1;
        exp_q.push_back(x);
        m_acc = 0;
    endtask

    task automatic step(output logic [3:0] obs, output logic [3:0] exp);
        ev_t x;
        @(posedge clk);
        edge_no = edge_no + 1;
        #1;
        obs = {bus.tick_os, bus.clk_bps, bus.mid_bps, bus.cfg_ack};
        exp = 4'b0000;
        if (exp_q.size() > 0 && exp_q[0].e == edge_no) begin
            x   = exp_q.pop_front();
            exp = x.v;
        end
    endtask

    task automatic test_reset();
        logic [3:0] obs, exp;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset edge %0d: got %b want %b", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_defaults();
        logic [3:0] obs, exp;
        int b, nx;
        b   = edge_no;
        rst = 1'b0;
        model_start(b + 1);
        model_ticks(6, 12, 24);
        // Enable drops on the edge where tick 25 would have been raised.
        for (nx = b + 1; nx <= b + 172; nx++) begin
            bus.band_sig = (nx < b + 168);
            step(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL defaults edge %0d: got %b want %b", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_int_divide();
        logic [3:0] obs, exp;
        int b, nx;
        b = edge_no;
        push_ev(b + 1, 4'b0001);
        model_start(b + 2);
        model_ticks(3, 0, 33);
        for (nx = b + 1; nx <= b + 104; nx++) begin
            bus.div_int  = 16'd3;
            bus.div_frac = 4'd0;
            bus.div_load = (nx == b + 1);
            bus.band_sig = (nx >= b + 2) && (nx <= b + 101);
            step(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL int_divide edge %0d: got %b want %b", edge_no, obs, exp);
            end
        end
    endtask

    task automatic test_live_reload();
        logic [3:0] obs, exp;
        int b, nx, last;
        for (int p = 0; p < 2; p++) begin
            b = edge_no;
            push_ev(b + 1, 4'b0001);
            model_start(b + 2);
            model_ticks(3, 0, 4);
            model_ticks(3, 0, 1);
            model_ack_last();
            model_ticks((p == 0) ? 5 : 4, 0, 6);
            last = m_t;
            for (nx = b + 1; nx <= last + 4; nx++) begin
                bus.div_int  = (nx == b + 14) ? 16'd5 : (nx == b + 15) ? 16'd4 : 16'd3;
                bus.div_frac = 4'd0;
                bus.div_load = (nx == b + 1) || (nx == b + 14) || ((p == 1) && (nx == b + 15));
                bus.band_sig = (nx >= b + 2) && (nx <= last + 1);
                step(obs, exp);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL live_reload%0d edge %0d: got %b want %b", p, edge_no, obs, exp);
                end
            end
        end
        bus.div_load = 1'b0;
    endtask

    task automatic test_resync();
        logic [3:0] obs, exp;
        int b, nx, last;
        b = edge_no;
        push_ev(b + 1, 4'b0001);
        model_start(b + 2);
        model_ticks(3, 0, 5);
        // Sync lands on the edge of the sixth tick, which must not appear.
        model_start(b + 19);
        model_ticks(3, 0, 18);
        last = m_t;
        for (nx = b + 1; nx <= last + 3; nx++) begin
            bus.div_int  = 16'd3;
            bus.div_frac = 4'd0;
            bus.div_load = (nx == b + 1);
            bus.sync     = (nx == b + 19);
            bus.band_sig = (nx >= b + 2) && (nx <= last + 1);
            step(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL resync edge %0d: got %b want %b", edge_no, obs, exp);
            end
        end
        bus.sync = 1'b0;
    endtask

    task automatic test_clamp();
        logic [3:0] obs, exp;
        int b, nx;
        for (int v = 1; v >= 0; v--) begin
            b = edge_no;
            push_ev(b + 1, 4'b0001);
            model_start(b + 2);
            model_ticks(2, 0, 10);
            for (nx = b + 1; nx <= b + 24; nx++) begin
                bus.div_int  = 16'(v);
                bus.div_frac = 4'd0;
                bus.div_load = (nx == b + 1);
                bus.band_sig = (nx >= b + 2) && (nx <= b + 22);
                step(obs, exp);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL clamp%0d edge %0d: got %b want %b", v, edge_no, obs, exp);
                end
            end
        end
        bus.div_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        int b, nx, last;
        b = edge_no;
        push_ev(b + 1, 4'b0001);
        model_start(b + 2);
        model_ticks(3, 0, 9);
        // Load pending at b+29; reset at b+30..b+31 must drop it with no ack.
        model_start(b + 32);
        model_ticks(6, 12, 17);
        last = m_t;
        for (nx = b + 1; nx <= last + 3; nx++) begin
            bus.div_int  = (nx == b + 29) ? 16'd5 : 16'd3;
            bus.div_frac = 4'd0;
            bus.div_load = (nx == b + 1) || (nx == b + 29);
            rst          = (nx == b + 30) || (nx == b + 31);
            bus.band_sig = (nx >= b + 2) && (nx <= last + 1);
            step(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid edge %0d: got %b want %b", edge_no, obs, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.band_sig = 1'b0;
        bus.sync     = 1'b0;
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.div_load = 1'b0;

        test_reset();
        test_defaults();
        test_int_divide();
        test_live_reload();
        test_resync();
        test_clamp();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
